// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generators and the PWM capture block.
//   pwm_state_t  : capture FSM state encoding (IDLE / HIGH / LOW)
//   DUTY_W       : width of the derived duty-cycle value
//   DUTY_SCALE   : full-scale duty value (high == period maps to this)
//   PWM_CLK_FREQ : default system clock frequency in Hz
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_t;

    localparam int DUTY_W       = 8;
    localparam int DUTY_SCALE   = 255;
    localparam int PWM_CLK_FREQ = 25_000_000;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: sequential restoring divider, duty = floor(num*255/den).
// One quotient bit per cycle, MSB first, DUTY_W steps.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands and (re)start; aborts a divide in flight
//   num, den   : high time and period (den must be nonzero, num <= den)
//   duty_o     : quotient, updated on the cycle done_o is high
//   done_o     : one-cycle pulse DUTY_W+1 cycles after start
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic [DUTY_W-1:0] duty_o,
    output logic              done_o
);

    localparam int NW = CNT_W + DUTY_W;

    logic [NW-1:0]     num_scaled;
    logic [NW-1:0]     rem;
    logic [NW-1:0]     dsh;
    logic [DUTY_W-1:0] q;
    logic [DUTY_W-1:0] q_nxt;
    logic              ge;
    // One-hot step tracker: bit i set means step i runs on the next edge;
    // the top bit is the done strobe.
    logic [DUTY_W:0]   vld_pipe;

    assign num_scaled = {{DUTY_W{1'b0}}, num} * NW'(DUTY_SCALE);
    assign ge         = (rem >= dsh);
    assign q_nxt      = {q[DUTY_W-2:0], ge};
    assign done_o     = vld_pipe[DUTY_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsh      <= '0;
            q        <= '0;
            duty_o   <= '0;
            vld_pipe <= '0;
        end else if (start) begin
            rem      <= num_scaled;
            // Divisor aligned to the quotient MSB: den << (DUTY_W-1).
            dsh      <= NW'({den, {(DUTY_W-1){1'b0}}});
            q        <= '0;
            vld_pipe <= {{DUTY_W{1'b0}}, 1'b1};
        end else begin
            vld_pipe <= {vld_pipe[DUTY_W-1:0], 1'b0};
            if (|vld_pipe[DUTY_W-1:0]) begin
                if (ge)
                    rem <= rem - dsh;
                dsh <= dsh >> 1;
                q   <= q_nxt;
            end
            if (vld_pipe[DUTY_W-1])
                duty_o <= q_nxt;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line.
//   clk, rst_n   : clock, async active-low reset
//   pwm_in       : PWM line, asynchronous to clk
//   period_o     : last complete period (rise to rise), in clk cycles
//   high_o       : high time belonging to that period
//   valid_o      : one-cycle strobe when period_o/high_o update
//   stuck_o      : no edge for TIMEOUT_CYC cycles; cleared by the next rise
//   level_o      : synchronized line level (qualifies stuck_o)
// Optional (macro PWM_CAPTURE_DUTY_EN):
//   duty_o       : floor(high_o*255/period_o), computed after each valid_o
//   duty_valid_o : one-cycle strobe 9 cycles after valid_o
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CLK_FREQ    = PWM_CLK_FREQ,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = CLK_FREQ / 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period_o,
    output logic [CNT_W-1:0]  high_o,
    output logic              valid_o,
    output logic              stuck_o,
    output logic              level_o
`ifdef PWM_CAPTURE_DUTY_EN
    ,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_valid_o
`endif
);

    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic                   prev;
    logic                   rise;
    logic                   fall;

    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       hi_lat;
    logic [CNT_W-1:0]       idle_cnt;
    pwm_state_t             state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // Synchronizer plus one extra flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
            prev    <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync    = sync_ff[SYNC_STAGES-1];
    assign rise    = sync & ~prev;
    assign fall    = ~sync & prev;
    assign level_o = sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            hi_lat   <= '0;
            idle_cnt <= '0;
            period_o <= '0;
            high_o   <= '0;
            valid_o  <= 1'b0;
            stuck_o  <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            per_cnt  <= rise ? '0 : sat_inc(per_cnt);
            hi_cnt   <= rise ? '0 : ((state == ST_HIGH) ? sat_inc(hi_cnt) : hi_cnt);
            idle_cnt <= (rise | fall) ? '0 : sat_inc(idle_cnt);
            valid_o  <= 1'b0;

            // An edge on the threshold cycle wins over the timeout.
            if (rise || fall) begin
                if (rise)
                    stuck_o <= 1'b0;
                case (state)
                    // Period leading up to this rise is incomplete: no report.
                    ST_IDLE: if (rise) state <= ST_HIGH;
                    ST_HIGH: if (fall) begin
                        hi_lat <= sat_inc(hi_cnt);
                        state  <= ST_LOW;
                    end
                    ST_LOW: if (rise) begin
                        period_o <= sat_inc(per_cnt);
                        high_o   <= hi_lat;
                        valid_o  <= 1'b1;
                        state    <= ST_HIGH;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (idle_cnt == TO_LAST) begin
                stuck_o <= 1'b1;
                state   <= ST_IDLE;
            end
        end
    end

`ifdef PWM_CAPTURE_DUTY_EN
    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_duty_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (valid_o),
        .num    (high_o),
        .den    (period_o),
        .duty_o (duty_o),
        .done_o (duty_valid_o)
    );
`endif

endmodule
